// File: rtl/hamming_stream_decoder.sv
// Serial Hamming / SECDED decoder. Codeword bits arrive one per accepted
// cycle in position order. A completed frame is decoded combinationally and
// captured into a single-entry output holding register.
module hamming_stream_decoder #(
    parameter int R      = 3,
    parameter int SECDED = 0,
    localparam int N     = (1 << R) - 1,
    localparam int K     = N - R,
    localparam int L     = N + SECDED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         frame_sync,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [K-1:0] data_out,
    output logic [R-1:0] syndrome_out,
    output logic         err_corrected,
    output logic         err_uncorrectable,
    output logic         overrun,
    output logic [R:0]   bit_cnt
);

    localparam logic [R:0] LAST = (R+1)'(L);

    // Position of the d-th data bit (d = 0 -> position 3), skipping powers of two.
    function automatic int data_pos(input int d);
        int cnt;
        data_pos = 0;
        cnt = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == d) data_pos = p;
                cnt++;
            end
        end
    endfunction

    logic [L:1]   frame_q, frame_d;
    logic [R:0]   cnt_q, cnt_d;
    logic         complete;
    logic [R-1:0] syn;
    logic         par, fix, corr, unc;
    logic [L:1]   cw;
    logic [K-1:0] dec_data;
    logic         load, drop;

    logic         out_valid_q, out_valid_d;
    logic [K-1:0] data_q;
    logic [R-1:0] syn_q;
    logic         corr_q, unc_q, overrun_q;

    // Frame assembly: frame_sync (only while enabled) restarts the frame and
    // can itself carry position 1; the cycle accepting the last bit completes it.
    always_comb begin
        frame_d  = frame_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        if (ena && frame_sync) begin
            if (bit_valid) begin
                frame_d[1] = bit_in;
                cnt_d      = (R+1)'(2);
            end else begin
                cnt_d      = (R+1)'(1);
            end
        end else if (ena && bit_valid) begin
            for (int p = 1; p <= L; p++)
                if (cnt_q == (R+1)'(p)) frame_d[p] = bit_in;
            if (cnt_q == LAST) begin
                complete = 1'b1;
                cnt_d    = (R+1)'(1);
            end else begin
                cnt_d    = cnt_q + (R+1)'(1);
            end
        end
    end

    // Decode the frame as it stands after this cycle's bit, so the result can
    // be captured on the completing edge.
    always_comb begin
        syn = '0;
        for (int p = 1; p <= N; p++)
            if (frame_d[p]) syn = syn ^ R'(p);
        par = ^frame_d;
        if (SECDED != 0) begin
            corr = par;
            fix  = par && (syn != '0);
            unc  = !par && (syn != '0);
        end else begin
            corr = (syn != '0);
            fix  = (syn != '0);
            unc  = 1'b0;
        end
        cw = frame_d;
        for (int p = 1; p <= N; p++)
            if (fix && syn == R'(p)) cw[p] = ~frame_d[p];
        dec_data = '0;
        for (int d = 0; d < K; d++)
            dec_data[d] = cw[data_pos(d)];
    end

    // Holding register handshake: load when empty or being drained this cycle.
    always_comb begin
        load        = complete && (!out_valid_q || out_ready);
        drop        = complete && out_valid_q && !out_ready;
        out_valid_d = out_valid_q;
        if (load)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
    end

    // State update with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q     <= '0;
            cnt_q       <= (R+1)'(1);
            out_valid_q <= 1'b0;
            data_q      <= '0;
            syn_q       <= '0;
            corr_q      <= 1'b0;
            unc_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_q     <= frame_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            if (load) begin
                data_q <= dec_data;
                syn_q  <= syn;
                corr_q <= corr;
                unc_q  <= unc;
            end
            if (drop) overrun_q <= 1'b1;
        end
    end

    assign out_valid         = out_valid_q;
    assign data_out          = data_q;
    assign syndrome_out      = syn_q;
    assign err_corrected     = corr_q;
    assign err_uncorrectable = unc_q;
    assign overrun           = overrun_q;
    assign bit_cnt           = cnt_q;

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Directed bench: one Hamming(7,4) instance and one SECDED(8,4) instance
// share the stimulus; each test resets and checks only the instance it targets.
module tb_hamming_stream_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1, ena = 1'b1, frame_sync = 1'b0, bit_in = 1'b0;
    logic bit_valid = 1'b0, out_ready = 1'b0;

    logic       h_vld, h_corr, h_unc, h_ovr;
    logic [3:0] h_data;
    logic [2:0] h_syn;
    logic [3:0] h_cnt;
    logic       s_vld, s_corr, s_unc, s_ovr;
    logic [3:0] s_data;
    logic [2:0] s_syn;
    logic [3:0] s_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hamming_stream_decoder #(.R(3), .SECDED(0)) u_h (
        .clk(clk), .rst(rst), .ena(ena), .frame_sync(frame_sync),
        .bit_in(bit_in), .bit_valid(bit_valid), .out_ready(out_ready),
        .out_valid(h_vld), .data_out(h_data), .syndrome_out(h_syn),
        .err_corrected(h_corr), .err_uncorrectable(h_unc),
        .overrun(h_ovr), .bit_cnt(h_cnt));

    hamming_stream_decoder #(.R(3), .SECDED(1)) u_s (
        .clk(clk), .rst(rst), .ena(ena), .frame_sync(frame_sync),
        .bit_in(bit_in), .bit_valid(bit_valid), .out_ready(out_ready),
        .out_valid(s_vld), .data_out(s_data), .syndrome_out(s_syn),
        .err_corrected(s_corr), .err_uncorrectable(s_unc),
        .overrun(s_ovr), .bit_cnt(s_cnt));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bit_valid = 1'b0; frame_sync = 1'b0; out_ready = 1'b0; ena = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_in = b; bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
    endtask

    // bits[0] is position 1
    task automatic send_bits(input logic [7:0] bits, input int first, input int last);
        for (int i = first; i <= last; i++) send_bit(bits[i]);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (h_vld !== 1'b0) $display("FAIL reset_vld got %b want 0", h_vld); else passed++;
        total++; if (h_data !== 4'h0) $display("FAIL reset_data got %h want 0", h_data); else passed++;
        total++; if (h_syn !== 3'd0) $display("FAIL reset_syn got %0d want 0", h_syn); else passed++;
        total++; if ({h_corr, h_unc, h_ovr} !== 3'b000) $display("FAIL reset_flags got %b want 000", {h_corr, h_unc, h_ovr}); else passed++;
        total++; if (h_cnt !== 4'd1) $display("FAIL reset_cnt got %0d want 1", h_cnt); else passed++;
        total++; if ({s_vld, s_unc, s_cnt} !== {1'b0, 1'b0, 4'd1}) $display("FAIL reset_secded got %b want 000001", {s_vld, s_unc, s_cnt}); else passed++;
    endtask

    task automatic test_clean();
        do_reset();
        send_bits(8'h55, 0, 5);
        total++; if (h_vld !== 1'b0) $display("FAIL clean_early_vld got %b want 0", h_vld); else passed++;
        total++; if (h_cnt !== 4'd7) $display("FAIL clean_cnt7 got %0d want 7", h_cnt); else passed++;
        send_bits(8'h55, 6, 6);
        total++; if (h_vld !== 1'b1) $display("FAIL clean_vld got %b want 1", h_vld); else passed++;
        total++; if (h_data !== 4'hB) $display("FAIL clean_data got %h want b", h_data); else passed++;
        total++; if (h_syn !== 3'd0) $display("FAIL clean_syn got %0d want 0", h_syn); else passed++;
        total++; if (h_corr !== 1'b0) $display("FAIL clean_corr got %b want 0", h_corr); else passed++;
        total++; if (h_cnt !== 4'd1) $display("FAIL clean_wrap got %0d want 1", h_cnt); else passed++;
        step(); step();
        total++; if ({h_vld, h_data} !== 5'h1B) $display("FAIL clean_hold got %h want 1b", {h_vld, h_data}); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (h_vld !== 1'b0) $display("FAIL clean_drain got %b want 0", h_vld); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_single_err();
        do_reset();
        send_bits(8'h75, 0, 6);
        total++; if (h_data !== 4'hB) $display("FAIL sec_data got %h want b", h_data); else passed++;
        total++; if (h_syn !== 3'd6) $display("FAIL sec_syn got %0d want 6", h_syn); else passed++;
        total++; if ({h_vld, h_corr, h_unc} !== 3'b110) $display("FAIL sec_flags got %b want 110", {h_vld, h_corr, h_unc}); else passed++;
    endtask

    task automatic test_secded();
        do_reset();
        send_bits(8'h41, 0, 7);
        total++; if (s_data !== 4'h8) $display("FAIL ded_data got %h want 8", s_data); else passed++;
        total++; if (s_syn !== 3'd6) $display("FAIL ded_syn got %0d want 6", s_syn); else passed++;
        total++; if ({s_vld, s_corr, s_unc} !== 3'b101) $display("FAIL ded_flags got %b want 101", {s_vld, s_corr, s_unc}); else passed++;
        do_reset();
        send_bits(8'hD5, 0, 7);
        total++; if ({s_data, s_syn} !== {4'hB, 3'd0}) $display("FAIL pbit_word got %h want 58", {s_data, s_syn}); else passed++;
        total++; if ({s_vld, s_corr, s_unc} !== 3'b110) $display("FAIL pbit_flags got %b want 110", {s_vld, s_corr, s_unc}); else passed++;
        do_reset();
        send_bits(8'h75, 0, 7);
        total++; if ({s_data, s_syn} !== {4'hB, 3'd6}) $display("FAIL secded1_word got %h want 5e", {s_data, s_syn}); else passed++;
        total++; if ({s_vld, s_corr, s_unc} !== 3'b110) $display("FAIL secded1_flags got %b want 110", {s_vld, s_corr, s_unc}); else passed++;
    endtask

    task automatic test_overrun();
        do_reset();
        send_bits(8'h55, 0, 6);
        send_bits(8'h00, 0, 6);
        total++; if ({h_vld, h_data} !== 5'h1B) $display("FAIL ovr_keep got %h want 1b", {h_vld, h_data}); else passed++;
        total++; if (h_ovr !== 1'b1) $display("FAIL ovr_flag got %b want 1", h_ovr); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (h_vld !== 1'b0) $display("FAIL ovr_drain got %b want 0", h_vld); else passed++;
        total++; if (h_ovr !== 1'b1) $display("FAIL ovr_sticky got %b want 1", h_ovr); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_bits(8'h55, 0, 6);
        send_bits(8'h00, 0, 5);
        out_ready = 1'b1;
        send_bits(8'h00, 6, 6);
        total++; if ({h_vld, h_data} !== 5'h10) $display("FAIL b2b_word got %h want 10", {h_vld, h_data}); else passed++;
        total++; if (h_ovr !== 1'b0) $display("FAIL b2b_ovr got %b want 0", h_ovr); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_frame_sync();
        do_reset();
        send_bits(8'h07, 0, 2);
        total++; if (h_cnt !== 4'd4) $display("FAIL fs_cnt4 got %0d want 4", h_cnt); else passed++;
        frame_sync = 1'b1;
        send_bit(1'b1);
        frame_sync = 1'b0;
        total++; if (h_cnt !== 4'd2) $display("FAIL fs_cnt2 got %0d want 2", h_cnt); else passed++;
        send_bits(8'h55, 1, 5);
        total++; if (h_vld !== 1'b0) $display("FAIL fs_early got %b want 0", h_vld); else passed++;
        ena = 1'b0;
        send_bit(1'b1);
        ena = 1'b1;
        total++; if ({h_vld, h_cnt} !== 5'h07) $display("FAIL fs_ena_freeze got %h want 07", {h_vld, h_cnt}); else passed++;
        send_bits(8'h55, 6, 6);
        total++; if ({h_vld, h_data, h_syn} !== 8'hD8) $display("FAIL fs_word got %h want d8", {h_vld, h_data, h_syn}); else passed++;
        out_ready = 1'b1;
        step(); step(); step();
        total++; if (h_vld !== 1'b0) $display("FAIL fs_one_word got %b want 0", h_vld); else passed++;
        out_ready = 1'b0;
        send_bits(8'h55, 0, 3);
        rst = 1'b1; frame_sync = 1'b1; bit_valid = 1'b1;
        step();
        rst = 1'b0; frame_sync = 1'b0; bit_valid = 1'b0;
        total++; if ({h_vld, h_cnt} !== 5'h01) $display("FAIL midrst got %h want 01", {h_vld, h_cnt}); else passed++;
        send_bits(8'h55, 0, 6);
        total++; if ({h_vld, h_data, h_syn} !== 8'hD8) $display("FAIL midrst_next got %h want d8", {h_vld, h_data, h_syn}); else passed++;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_err();
        test_secded();
        test_overrun();
        test_back_to_back();
        test_frame_sync();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hamming_stream_decoder.md
HAMMING_STREAM_DECODER -- requirements
Module: hamming_stream_decoder

Interface
REQ-001 SHALL have parameter R, default 3, meaning parity bits per codeword; legal range 3..5; N = 2^R-1 codeword bits, K = N-R data bits.
REQ-002 SHALL have parameter SECDED, default 0, meaning 1 = one extra overall-parity bit per frame (N+1 bits) with double-error detection.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ena  input  1  reception enable; low freezes bit counter and shift register.
REQ-006 SHALL have port frame_sync  input  1  aborts the partial frame and restarts at codeword position 1.
REQ-007 SHALL have port bit_in  input  1  serial codeword bit.
REQ-008 SHALL have port bit_valid  input  1  qualifies bit_in.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the held word.
REQ-010 SHALL have port out_valid  output  1  decoded word held.
REQ-011 SHALL have port data_out  output  K  decoded data.
REQ-012 SHALL have port syndrome_out  output  R  syndrome of the held word.
REQ-013 SHALL have port err_corrected  output  1  single error corrected in the held word.
REQ-014 SHALL have port err_uncorrectable  output  1  double error detected in the held word (SECDED=1 only, else tied 0).
REQ-015 SHALL have port overrun  output  1  sticky: at least one completed word dropped.
REQ-016 SHALL have port bit_cnt  output  R+1  position of the next expected bit, 1-based.

Function
REQ-017 SHALL accept a bit when ena=1 and bit_valid=1; bits arrive in position order 1..N, then the overall-parity bit if SECDED=1.
REQ-018 SHALL give frame_sync priority: when asserted, the frame restarts; a simultaneous accepted bit is stored as position 1 and bit_cnt becomes 2, else bit_cnt becomes 1.
REQ-019 SHALL wrap bit_cnt from the last position to 1 on the cycle that accepts the last bit (frame complete).
REQ-020 SHALL place parity bits at power-of-two positions; data_out[i] SHALL be the i-th non-power-of-two position in ascending order (data_out[0] = position 3).
REQ-021 SHALL compute the syndrome as the XOR of the position indices of all 1 bits among positions 1..N.
REQ-022 SHALL, for SECDED=0 and a nonzero syndrome, invert the bit at the syndrome position and set err_corrected.
REQ-023 SHALL, for SECDED=1 with P = XOR of all N+1 bits, decode as follows:
- S=0, P=0: clean.
- S!=0, P=1: correct position S, err_corrected=1.
- S=0, P=1: parity-bit error, data unchanged, err_corrected=1.
- S!=0, P=0: err_uncorrectable=1, data passed uncorrected.
REQ-024 SHALL load the decoded result into the output holding register and raise out_valid on the cycle after the cycle that completed the frame (latency 1).
REQ-025 SHALL keep data_out, syndrome_out and the error flags stable while out_valid=1 and out_ready=0.
REQ-026 SHALL clear out_valid the cycle after out_valid=1 and out_ready=1, unless a new word loads in that same cycle.
REQ-027 SHALL, when a frame completes in the same cycle as out_valid=1 and out_ready=1, load the new word and keep out_valid=1, with no overrun.
REQ-028 SHALL, when a frame completes while out_valid=1 and out_ready=0, drop the new word, keep the held word, and set overrun.
REQ-029 SHALL continue accepting bits for the next frame while a word is held.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, set out_valid=0, data_out=0, syndrome_out=0, err_corrected=0, err_uncorrectable=0, overrun=0, bit_cnt=1, and clear the shift register.
REQ-031 SHALL discard a partial frame when reset occurs mid-frame; rst SHALL override ena, frame_sync and bit_valid.

Verification
REQ-032 SHALL pass: R=3, SECDED=0, bits 1,0,1,0,1,0,1 -> out_valid after 1 cycle, data_out=4'hB, syndrome_out=0, err_corrected=0.
REQ-033 SHALL pass: same stream with the 6th bit sent as 1 -> data_out=4'hB, syndrome_out=6, err_corrected=1.
REQ-034 SHALL pass: R=3, SECDED=1, bits 1,0,0,0,0,0,1,0 -> data_out=4'h8, syndrome_out=6, err_uncorrectable=1, err_corrected=0.
REQ-035 SHALL pass: R=3, SECDED=1, bits 1,0,1,0,1,0,1,1 -> data_out=4'hB, syndrome_out=0, err_corrected=1.
REQ-036 SHALL pass: two back-to-back clean frames with out_ready=0 -> first word retained, overrun=1; then out_ready=1 -> out_valid=0 next cycle, overrun stays 1.
REQ-037 SHALL pass: 3 bits, then frame_sync with bit_valid=1, then 6 more bits of a clean frame -> exactly one word delivered; rst mid-frame -> bit_cnt=1, out_valid=0.
